// File: rtl/branch_resolve_ctrl.sv
// Branch resolution sequencer: holds one decoded branch until its operands are
// final, evaluates the condition, and issues a PC redirect plus a timed IF/ID flush.
module branch_resolve_ctrl #(
  parameter int PC_W         = 32,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             br_valid,
  output logic             br_ready,
  input  logic [2:0]       br_cond,
  input  logic [PC_W-1:0]  br_pc,
  input  logic [15:0]      br_imm,
  input  logic             opnd_ok,
  input  logic [31:0]      rs_val,
  input  logic [31:0]      rt_val,
  output logic             redirect,
  output logic [PC_W-1:0]  redirect_pc,
  output logic             flush,
  output logic             stall_fe,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  localparam int FC_W = $clog2(FLUSH_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FLUSH} state_t;

  state_t          state, state_nxt;
  logic [2:0]      cond_q;
  logic [PC_W-1:0] pc_q;
  logic [15:0]     imm_q;
  logic [FC_W-1:0] fcnt;
  logic            taken, resolve, rs_zero;
  logic [PC_W-1:0] offs, target;

  assign br_ready = (state == S_IDLE);
  assign stall_fe = (state != S_IDLE);
  assign flush    = (state == S_FLUSH);
  assign resolve  = (state == S_WAIT) && opnd_ok;
  assign rs_zero  = (rs_val == 32'd0);

  always_comb begin
    taken = 1'b0;
    case (cond_q)
      3'b000:  taken = ~rs_val[31];
      3'b001:  taken = rs_val[31];
      3'b010:  taken = ~rs_val[31] & ~rs_zero;
      3'b011:  taken = rs_val[31] | rs_zero;
      3'b100:  taken = (rs_val == rt_val);
      3'b101:  taken = (rs_val != rt_val);
      3'b110:  taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  // Word offset sign-extended to PC width; the sum wraps modulo 2^PC_W.
  always_comb begin
    offs       = {PC_W{imm_q[15]}};
    offs[17:0] = {imm_q, 2'b00};
    target     = pc_q + PC_W'(4) + offs;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (br_valid) state_nxt = S_WAIT;
      S_WAIT:  if (opnd_ok) state_nxt = taken ? S_FLUSH : S_IDLE;
      S_FLUSH: if (fcnt == FC_W'(1)) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      fcnt  <= '0;
    end else begin
      state <= state_nxt;
      if (resolve && taken)
        fcnt <= FC_W'(FLUSH_CYCLES);
      else if (state == S_FLUSH)
        fcnt <= fcnt - FC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cond_q <= '0;
      pc_q   <= '0;
      imm_q  <= '0;
    end else if (br_ready && br_valid) begin
      cond_q <= br_cond;
      pc_q   <= br_pc;
      imm_q  <= br_imm;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect    <= 1'b0;
      redirect_pc <= '0;
    end else begin
      redirect <= resolve && taken;
      if (resolve && taken) redirect_pc <= target;
    end
  end

  // Both counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_cnt <= '0;
      taken_cnt  <= '0;
    end else if (resolve) begin
      if (branch_cnt != '1)         branch_cnt <= branch_cnt + CNT_W'(1);
      if (taken && taken_cnt != '1) taken_cnt  <= taken_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Randomized scoreboard bench for branch_resolve_ctrl with a reference model of
// the branch rules; a negedge monitor pops expectations at each resolution.
module tb_branch_resolve_ctrl;
  localparam int PW = 32, FC = 3, CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          br_valid = 1'b0, br_ready, opnd_ok = 1'b0;
  logic [2:0]    br_cond = '0;
  logic [PW-1:0] br_pc = '0, redirect_pc;
  logic [15:0]   br_imm = '0;
  logic [31:0]   rs_val = '0, rt_val = '0;
  logic          redirect, flush, stall_fe;
  logic [CW-1:0] branch_cnt, taken_cnt;

  branch_resolve_ctrl #(.PC_W(PW), .FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .br_ready(br_ready),
    .br_cond(br_cond), .br_pc(br_pc), .br_imm(br_imm), .opnd_ok(opnd_ok),
    .rs_val(rs_val), .rt_val(rt_val), .redirect(redirect),
    .redirect_pc(redirect_pc), .flush(flush), .stall_fe(stall_fe),
    .branch_cnt(branch_cnt), .taken_cnt(taken_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          tk;
    logic [31:0] pc;
    int          bcnt;
    int          tcnt;
  } exp_t;

  exp_t        q[$];
  int          errors = 0, checks = 0;
  int          m_bcnt = 0, m_tcnt = 0;
  logic [31:0] m_last = '0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit ref_taken(logic [2:0] c, logic [31:0] rs, logic [31:0] rt);
    int signed s;
    s = rs;
    case (c)
      3'd0: return s >= 0;
      3'd1: return s < 0;
      3'd2: return s > 0;
      3'd3: return s <= 0;
      3'd4: return rs == rt;
      3'd5: return rs != rt;
      3'd6: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ref_target(logic [31:0] pc, logic [15:0] imm);
    longint t;
    t = longint'(pc) + 64'sd4 + 64'sd4 * longint'($signed(imm));
    return t[31:0];
  endfunction

  // Issue one branch; operands become final after 'delay' cycles of garbage.
  task automatic send(logic [2:0] c, logic [31:0] pc, logic [15:0] imm,
                      logic [31:0] rs, logic [31:0] rt, int delay);
    int n;
    bit tk;
    @(negedge clk);
    br_valid = 1'b1; br_cond = c; br_pc = pc; br_imm = imm;
    opnd_ok = 1'($urandom); rs_val = $urandom; rt_val = $urandom;
    n = 0;
    while (!br_ready && n < 100) begin
      @(negedge clk);
      opnd_ok = 1'($urandom);
      n++;
    end
    if (!br_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: br_ready stayed 0 for %0d cycles", n);
      br_valid = 1'b0; opnd_ok = 1'b0;
      return;
    end
    @(negedge clk);
    br_valid = 1'b0; br_cond = 3'($urandom); br_pc = $urandom; br_imm = 16'($urandom);
    for (int i = 0; i < delay; i++) begin
      opnd_ok = 1'b0; rs_val = $urandom; rt_val = $urandom;
      @(negedge clk);
    end
    opnd_ok = 1'b1; rs_val = rs; rt_val = rt;
    tk = ref_taken(c, rs, rt);
    m_bcnt = (m_bcnt < CMAX) ? m_bcnt + 1 : CMAX;
    if (tk) begin
      m_tcnt = (m_tcnt < CMAX) ? m_tcnt + 1 : CMAX;
      m_last = ref_target(pc, imm);
    end
    q.push_back('{tk, m_last, m_bcnt, m_tcnt});
    @(negedge clk);
    opnd_ok = 1'b0; rs_val = $urandom; rt_val = $urandom;
  endtask

  task automatic drain();
    int n;
    n = 0;
    @(negedge clk);
    while ((!br_ready || q.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_idle", {63'd0, br_ready}, 64'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    br_valid = 1'b0; opnd_ok = 1'b0;
    m_bcnt = 0; m_tcnt = 0; m_last = '0;
    q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: a resolution is either a redirect pulse or WAIT falling straight to IDLE.
  bit p_stall = 1'b0, p_flush = 1'b0;
  int flen = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      p_stall = 1'b0; p_flush = 1'b0; flen = 0;
    end else begin
      bit res_t, res_n;
      exp_t e;
      chk("stall_vs_ready", {63'd0, stall_fe}, {63'd0, !br_ready});
      res_t = redirect;
      res_n = p_stall && !p_flush && !stall_fe && !redirect;
      if (res_t || res_n) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_resolve: redirect=%0b with no branch pending", redirect);
        end else begin
          e = q.pop_front();
          chk("taken", {63'd0, res_t}, {63'd0, e.tk});
          chk("redirect_pc", 64'(redirect_pc), 64'(e.pc));
          chk("branch_cnt", 64'(branch_cnt), 64'(e.bcnt));
          chk("taken_cnt", 64'(taken_cnt), 64'(e.tcnt));
          if (res_t) chk("flush_with_redirect", {63'd0, flush}, 64'd1);
          else       chk("ready_after_not_taken", {63'd0, br_ready}, 64'd1);
        end
      end
      if (flush) flen++;
      else if (p_flush) begin
        chk("flush_len", 64'(flen), 64'(FC));
        chk("ready_after_flush", {63'd0, br_ready}, 64'd1);
        flen = 0;
      end
      p_stall = stall_fe; p_flush = flush;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rs, rt;
    #1;
    chk("rst_ready", {63'd0, br_ready}, 64'd1);
    chk("rst_redirect", {63'd0, redirect}, 64'd0);
    chk("rst_flush", {63'd0, flush}, 64'd0);
    chk("rst_redirect_pc", 64'(redirect_pc), 64'd0);
    chk("rst_bcnt", 64'(branch_cnt), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    send(3'd4, 32'h100, 16'd3, 32'd5, 32'd5, 0);
    drain();
    do_reset();
    send(3'd2, 32'h200, 16'hFFFF, 32'd0, 32'd7, 0);
    send(3'd2, 32'h200, 16'hFFFF, 32'd1, 32'd7, 0);
    drain();
    send(3'd1, 32'h400, 16'd8, 32'hFFFF_FFFF, 32'd0, 3);
    drain();

    // Asynchronous reset while flushing.
    send(3'd6, 32'h500, 16'd4, 32'd0, 32'd0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_flush", {63'd0, flush}, 64'd0);
    chk("arst_redirect", {63'd0, redirect}, 64'd0);
    chk("arst_ready", {63'd0, br_ready}, 64'd1);
    chk("arst_bcnt", 64'(branch_cnt), 64'd0);
    chk("arst_tcnt", 64'(taken_cnt), 64'd0);
    m_bcnt = 0; m_tcnt = 0; m_last = '0;
    q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    send(3'd6, 32'hFFFF_FFF8, 16'd1, 32'd0, 32'd0, 1);
    drain();
    do_reset();
    for (int i = 0; i < 20; i++) send(3'd6, 32'($urandom), 16'($urandom), $urandom, $urandom, i % 3);
    drain();
    chk("sat_branch_cnt", 64'(branch_cnt), 64'(CMAX));
    chk("sat_taken_cnt", 64'(taken_cnt), 64'(CMAX));

    do_reset();
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 3))
        0: rs = 32'd0;
        1: rs = 32'd1;
        2: rs = 32'hFFFF_FFFF;
        default: rs = $urandom;
      endcase
      rt = ($urandom_range(0, 1) == 0) ? rs : $urandom;
      send(3'($urandom), 32'($urandom), 16'($urandom), rs, rt, $urandom_range(0, 4));
      if (i % 12 == 11) begin
        drain();
        do_reset();
      end
    end
    drain();
    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
